// File: rtl/keypad_scanner.sv
// 4x3 keypad column scanner with row synchronizer, full-scan debounce and key encoding.
// Optional auto-repeat strobes are enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 60000,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key_code,
  output logic       is_pressed,
  output logic       star_pressed,
  output logic       key_strobe
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [3:0]  KEY_NONE = 4'hF;
  localparam logic [3:0]  KEY_STAR = 4'd10;

  typedef enum logic [1:0] {COL0, COL1, COL2} col_state_e;

  col_state_e       state_q, state_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [3:0]       col0_hits_q, col1_hits_q;
  logic [3:0]       scan_q, scan_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_strobe_q, key_strobe_d;
  logic             dwell_end, scan_end, key_update, rep_strobe;
  logic [11:0]      hit_vec;
  logic [3:0]       scan_code;

  function automatic logic [3:0] key_map(input int unsigned idx);
    case (idx)
      0:  key_map = 4'd1;
      1:  key_map = 4'd2;
      2:  key_map = 4'd3;
      3:  key_map = 4'd4;
      4:  key_map = 4'd5;
      5:  key_map = 4'd6;
      6:  key_map = 4'd7;
      7:  key_map = 4'd8;
      8:  key_map = 4'd9;
      9:  key_map = KEY_STAR;
      10: key_map = 4'd0;
      11: key_map = 4'd11;
      default: key_map = KEY_NONE;
    endcase
  endfunction

  assign dwell_end = (dwell_q == DIV_W'(SCAN_DIV - 1));
  assign scan_end  = dwell_end && (state_q == COL2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COL0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + 1'b1;
    if (dwell_end) begin
      dwell_d = '0;
      unique case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL0;
        default: state_d = COL0;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      COL0:    col_n = 3'b110;
      COL1:    col_n = 3'b101;
      COL2:    col_n = 3'b011;
      default: col_n = 3'b110;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      col0_hits_q <= '0;
      col1_hits_q <= '0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      if (dwell_end && state_q == COL0) col0_hits_q <= ~row_sync_q;
      if (dwell_end && state_q == COL1) col1_hits_q <= ~row_sync_q;
    end
  end

  // Column 2 is taken straight from the synchronizer on its last dwell clock.
  always_comb begin
    logic [3:0] n_active;
    logic [3:0] found;
    n_active = '0;
    found    = KEY_NONE;
    hit_vec  = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      hit_vec[r*3 + 0] = col0_hits_q[r];
      hit_vec[r*3 + 1] = col1_hits_q[r];
      hit_vec[r*3 + 2] = ~row_sync_q[r];
    end
    for (int unsigned i = 0; i < 12; i++) begin
      if (hit_vec[i]) begin
        n_active = n_active + 1'b1;
        found    = key_map(i);
      end
    end
    scan_code = (n_active == 4'd1) ? found : KEY_NONE;
  end

  always_comb begin
    scan_d   = scan_q;
    stable_d = stable_q;
    if (scan_end) begin
      scan_d = scan_code;
      if (scan_code == scan_q)
        stable_d = (stable_q == STB_W'(DEBOUNCE_SCANS)) ? stable_q : stable_q + 1'b1;
      else
        stable_d = STB_W'(1);
    end
  end

  assign key_update   = (stable_q == STB_W'(DEBOUNCE_SCANS)) && (scan_q != key_code_q);
  assign key_code_d   = key_update ? scan_q : key_code_q;
  assign key_strobe_d = (key_update && (scan_q != KEY_NONE)) || rep_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q       <= KEY_NONE;
      stable_q     <= '0;
      key_code_q   <= KEY_NONE;
      key_strobe_q <= 1'b0;
    end else begin
      scan_q       <= scan_d;
      stable_q     <= stable_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;

  logic [REP_W-1:0] rep_q, rep_d;
  logic             scan_done_q;
  logic             repeatable;

  assign repeatable = (key_code_q != KEY_NONE) && (key_code_q != KEY_STAR);

  // Counting on the delayed scan pulse keeps repeats in phase with the first strobe.
  always_comb begin
    rep_d      = rep_q;
    rep_strobe = 1'b0;
    if (key_update) begin
      rep_d = '0;
    end else if (scan_done_q && repeatable) begin
      if (rep_q == REP_W'(REPEAT_SCANS - 1)) begin
        rep_d      = '0;
        rep_strobe = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      scan_done_q <= scan_end;
    end
  end
`else
  assign rep_strobe = 1'b0;
`endif

  assign key_code     = key_code_q;
  assign key_strobe   = key_strobe_q;
  assign is_pressed   = (key_code_q != KEY_NONE) && (key_code_q != KEY_STAR);
  assign star_pressed = (key_code_q == KEY_STAR);

endmodule
